// File: rtl/vga_plot_arbiter_if.sv
// Drawing-engine side of the VGA plot arbiter: per-requester request,
// pixel stream (valid/last/coordinates/colour) and the one-hot grant.
// The four engines drive the master modport, the arbiter uses slave.
interface vga_plot_arbiter_if;
    logic [3:0]  req;     // bit i = requester i wants the port
    logic [3:0]  valid;   // pixel valid, meaningful only while granted
    logic [3:0]  last;    // final pixel of the burst, qualified by valid
    logic [31:0] x_in;    // [8i+7:8i] = requester i x coordinate
    logic [27:0] y_in;    // [7i+6:7i] = requester i y coordinate
    logic [11:0] col_in;  // [3i+2:3i] = requester i colour
    logic [3:0]  gnt;     // one-hot grant, zero when idle

    modport master (
        output req,
        output valid,
        output last,
        output x_in,
        output y_in,
        output col_in,
        input  gnt
    );

    modport slave (
        input  req,
        input  valid,
        input  last,
        input  x_in,
        input  y_in,
        input  col_in,
        output gnt
    );
endinterface

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single vga_adapter write port among four
// drawing engines. Round-robin across bursts; a grant is held until the
// owner's last pixel or until the owner drops its request. Off-screen
// pixels are suppressed and counted in a saturating drop counter.
// Optional watchdog (macro PLOT_ARB_WATCHDOG_EN): forcibly releases an
// owner that stays idle for WDOG_CYCLES granted cycles and pulses wdog_trip.
module vga_plot_arbiter #(
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120
`ifdef PLOT_ARB_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES   = 1024
`endif
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    vga_plot_arbiter_if.slave eng,
    output logic [7:0]        VGA_X,
    output logic [6:0]        VGA_Y,
    output logic [2:0]        color_to_display,
    output logic              plot,
    output logic              busy,
    output logic [7:0]        drop_cnt
`ifdef PLOT_ARB_WATCHDOG_EN
    ,
    output logic              wdog_trip
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Registered state and outputs
    state_t      r_state;
    logic [1:0]  r_owner;
    logic [1:0]  r_rr;
    logic [3:0]  r_gnt;
    logic [7:0]  r_vga_x;
    logic [6:0]  r_vga_y;
    logic [2:0]  r_col;
    logic        r_plot;
    logic        r_busy;
    logic [7:0]  r_drop;

    // Next-state values
    state_t      w_state_next;
    logic [1:0]  w_owner_next;
    logic [1:0]  w_rr_next;
    logic [3:0]  w_gnt_next;
    logic [7:0]  w_vga_x_next;
    logic [6:0]  w_vga_y_next;
    logic [2:0]  w_col_next;
    logic        w_plot_next;
    logic        w_busy_next;
    logic [7:0]  w_drop_next;
    logic        w_release;

    // Unpacked per-requester pixel fields
    logic [7:0]  w_x   [4];
    logic [6:0]  w_y   [4];
    logic [2:0]  w_col [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign w_x[gi]   = eng.x_in[8*gi +: 8];
            assign w_y[gi]   = eng.y_in[7*gi +: 7];
            assign w_col[gi] = eng.col_in[3*gi +: 3];
        end
    endgenerate

    // Owner view: everything from non-owners is ignored
    logic        w_own_req;
    logic        w_own_valid;
    logic        w_own_last;
    logic [7:0]  w_own_x;
    logic [6:0]  w_own_y;
    logic [2:0]  w_own_col;
    logic        w_on_screen;

    assign w_own_req   = eng.req[r_owner];
    assign w_own_valid = eng.valid[r_owner];
    assign w_own_last  = eng.last[r_owner];
    assign w_own_x     = w_x[r_owner];
    assign w_own_y     = w_y[r_owner];
    assign w_own_col   = w_col[r_owner];
    assign w_on_screen = (32'(w_own_x) < SCREEN_WIDTH) &&
                         (32'(w_own_y) < SCREEN_HEIGHT);

    // Round-robin pick: first requesting index searching upward from rr+1
    logic [1:0]  w_sel;
    logic [1:0]  w_idx;
    logic        w_found;

    // Rotating priority search over the four requesters
    always_comb begin
        w_sel   = 2'd0;
        w_idx   = 2'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_rr + 2'(k);
            if (!w_found && eng.req[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    logic w_wdog_fire;

`ifdef PLOT_ARB_WATCHDOG_EN
    // Counter must hold WDOG_CYCLES and never be narrower than 10 bits
    localparam int WDW = ($clog2(WDOG_CYCLES + 1) > 10) ? $clog2(WDOG_CYCLES + 1) : 10;

    logic [WDW-1:0] r_idle;
    logic [WDW-1:0] w_idle_next;
    logic           r_wdog_trip;

    // The WDOG_CYCLES-th consecutive idle granted cycle forces release
    assign w_wdog_fire = (r_state == GRANT) && !w_own_valid &&
                         (r_idle == WDW'(WDOG_CYCLES - 1));

    // Idle counter: counts granted cycles without a valid owner pixel
    always_comb begin
        w_idle_next = '0;
        if (r_state == GRANT && !w_own_valid && !w_wdog_fire && !w_release) begin
            w_idle_next = r_idle + 1'b1;
        end
    end

    // Watchdog registers; trip is a single-cycle pulse on forced release
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_idle      <= '0;
            r_wdog_trip <= 1'b0;
        end else begin
            r_idle      <= w_idle_next;
            r_wdog_trip <= w_wdog_fire;
        end
    end

    assign wdog_trip = r_wdog_trip;
`else
    assign w_wdog_fire = 1'b0;
`endif

    // Next-state and output decode for the IDLE/GRANT machine
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_rr_next    = r_rr;
        w_gnt_next   = r_gnt;
        w_vga_x_next = r_vga_x;
        w_vga_y_next = r_vga_y;
        w_col_next   = r_col;
        w_plot_next  = 1'b0;
        w_busy_next  = r_busy;
        w_drop_next  = r_drop;
        w_release    = 1'b0;

        case (r_state)
            IDLE: begin
                if (|eng.req) begin
                    w_state_next = GRANT;
                    w_owner_next = w_sel;
                    w_gnt_next   = 4'b0001 << w_sel;
                    w_busy_next  = 1'b1;
                end
            end
            GRANT: begin
                // Accept one owner pixel per valid cycle, no backpressure
                if (w_own_valid) begin
                    if (w_on_screen) begin
                        w_vga_x_next = w_own_x;
                        w_vga_y_next = w_own_y;
                        w_col_next   = w_own_col;
                        w_plot_next  = 1'b1;
                    end else if (r_drop != 8'hFF) begin
                        w_drop_next = r_drop + 8'd1;
                    end
                end
                // Burst ends on last, on request withdrawal, or on watchdog
                w_release = (w_own_valid && w_own_last) || !w_own_req || w_wdog_fire;
                if (w_release) begin
                    w_state_next = IDLE;
                    w_gnt_next   = 4'b0000;
                    w_busy_next  = 1'b0;
                    w_rr_next    = r_owner;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_gnt_next   = 4'b0000;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight pixel
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_rr    <= 2'd3;
            r_gnt   <= 4'b0000;
            r_vga_x <= 8'd0;
            r_vga_y <= 7'd0;
            r_col   <= 3'd0;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
            r_drop  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_rr    <= w_rr_next;
            r_gnt   <= w_gnt_next;
            r_vga_x <= w_vga_x_next;
            r_vga_y <= w_vga_y_next;
            r_col   <= w_col_next;
            r_plot  <= w_plot_next;
            r_busy  <= w_busy_next;
            r_drop  <= w_drop_next;
        end
    end

    assign eng.gnt          = r_gnt;
    assign VGA_X            = r_vga_x;
    assign VGA_Y            = r_vga_y;
    assign color_to_display = r_col;
    assign plot             = r_plot;
    assign busy             = r_busy;
    assign drop_cnt         = r_drop;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed testbench for vga_plot_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are checked at the same point, after the edge
// that produced them has settled.
module tb_vga_plot_arbiter;

    logic       CLOCK_50;
    logic       resetn;
    logic [7:0] VGA_X;
    logic [6:0] VGA_Y;
    logic [2:0] color_to_display;
    logic       plot;
    logic       busy;
    logic [7:0] drop_cnt;
`ifdef PLOT_ARB_WATCHDOG_EN
    logic       wdog_trip;
`endif

    int errors = 0;
    int checks = 0;

    vga_plot_arbiter_if eng ();

`ifdef PLOT_ARB_WATCHDOG_EN
    vga_plot_arbiter #(.WDOG_CYCLES(16)) dut (
`else
    vga_plot_arbiter dut (
`endif
        .CLOCK_50         (CLOCK_50),
        .resetn           (resetn),
        .eng              (eng),
        .VGA_X            (VGA_X),
        .VGA_Y            (VGA_Y),
        .color_to_display (color_to_display),
        .plot             (plot),
        .busy             (busy),
        .drop_cnt         (drop_cnt)
`ifdef PLOT_ARB_WATCHDOG_EN
        ,
        .wdog_trip        (wdog_trip)
`endif
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic clear_inputs;
        eng.req    = 4'b0000;
        eng.valid  = 4'b0000;
        eng.last   = 4'b0000;
        eng.x_in   = '0;
        eng.y_in   = '0;
        eng.col_in = '0;
    endtask

    task automatic set_pix(input int r, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic v, input logic l);
        eng.x_in[8*r +: 8]   = x;
        eng.y_in[7*r +: 7]   = y;
        eng.col_in[3*r +: 3] = c;
        eng.valid[r]         = v;
        eng.last[r]          = l;
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        clear_inputs();
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if (eng.gnt !== 4'b0 || plot !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0 ||
            VGA_X !== 8'd0 || VGA_Y !== 7'd0 || color_to_display !== 3'd0) begin
            errors++;
            $display("FAIL reset_values gnt=%b plot=%b busy=%b drop=%0d x=%0d y=%0d c=%0d exp all zero",
                     eng.gnt, plot, busy, drop_cnt, VGA_X, VGA_Y, color_to_display);
        end
        tick();
        checks++;
        if (eng.gnt !== 4'b0 || plot !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle gnt=%b plot=%b exp gnt=0000 plot=0", eng.gnt, plot);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_burst;
        do_reset();
        eng.req = 4'b0001;
        set_pix(1, 8'd99, 7'd9, 3'd1, 1'b1, 1'b1);   // non-owner noise
        tick();
        checks++;
        if (eng.gnt !== 4'b0001 || busy !== 1'b1 || plot !== 1'b0) begin
            errors++;
            $display("FAIL basic_grant gnt=%b busy=%b plot=%b exp 0001 1 0", eng.gnt, busy, plot);
        end
        for (int i = 0; i < 3; i++) begin
            set_pix(0, 8'(10 + i), 7'd20, 3'd7, 1'b1, (i == 2));
            tick();
            checks++;
            if (plot !== 1'b1 || VGA_X !== 8'(10 + i) || VGA_Y !== 7'd20 || color_to_display !== 3'd7) begin
                errors++;
                $display("FAIL basic_pix%0d plot=%b x=%0d y=%0d c=%0d exp 1 %0d 20 7",
                         i, plot, VGA_X, VGA_Y, color_to_display, 10 + i);
            end
            checks++;
            if (eng.gnt !== ((i == 2) ? 4'b0000 : 4'b0001)) begin
                errors++;
                $display("FAIL basic_gnt%0d gnt=%b exp %b", i, eng.gnt, (i == 2) ? 4'b0000 : 4'b0001);
            end
        end
        clear_inputs();
        tick();
        checks++;
        if (plot !== 1'b0 || eng.gnt !== 4'b0 || busy !== 1'b0 || VGA_X !== 8'd12) begin
            errors++;
            $display("FAIL basic_after plot=%b gnt=%b busy=%b x=%0d exp 0 0000 0 12", plot, eng.gnt, busy, VGA_X);
        end
        $display("test_basic_burst done");
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        do_reset();
        for (int i = 0; i < 4; i++) set_pix(i, 8'(30 + i), 7'(i), 3'(i + 1), 1'b1, 1'b1);
        eng.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();
            checks++;
            if (eng.gnt !== exp_g) begin
                errors++;
                $display("FAIL rr_grant%0d gnt=%b exp %b", k, eng.gnt, exp_g);
            end
            tick();
            checks++;
            if (eng.gnt !== 4'b0 || plot !== 1'b1 || VGA_X !== 8'(30 + (k % 4))) begin
                errors++;
                $display("FAIL rr_gap%0d gnt=%b plot=%b x=%0d exp 0000 1 %0d", k, eng.gnt, plot, VGA_X, 30 + (k % 4));
            end
        end
        clear_inputs();
        $display("test_round_robin done");
    endtask

    task automatic test_offscreen_drop;
        do_reset();
        eng.req = 4'b0100;
        set_pix(0, 8'd99, 7'd1, 3'd1, 1'b1, 1'b0);   // non-owner, not requesting
        tick();
        checks++;
        if (eng.gnt !== 4'b0100) begin
            errors++;
            $display("FAIL drop_grant gnt=%b exp 0100", eng.gnt);
        end
        set_pix(2, 8'd200, 7'd5, 3'd1, 1'b1, 1'b0);
        tick();
        checks++;
        if (plot !== 1'b0 || drop_cnt !== 8'd1 || VGA_X !== 8'd0) begin
            errors++;
            $display("FAIL drop_x200 plot=%b drop=%0d x=%0d exp 0 1 0", plot, drop_cnt, VGA_X);
        end
        set_pix(2, 8'd5, 7'd120, 3'd2, 1'b1, 1'b0);
        tick();
        checks++;
        if (plot !== 1'b0 || drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL drop_y120 plot=%b drop=%0d exp 0 2", plot, drop_cnt);
        end
        set_pix(2, 8'd160, 7'd0, 3'd3, 1'b1, 1'b0);
        tick();
        checks++;
        if (plot !== 1'b0 || drop_cnt !== 8'd3) begin
            errors++;
            $display("FAIL drop_x160 plot=%b drop=%0d exp 0 3", plot, drop_cnt);
        end
        set_pix(2, 8'd159, 7'd119, 3'd5, 1'b1, 1'b1);
        tick();
        checks++;
        if (plot !== 1'b1 || VGA_X !== 8'd159 || VGA_Y !== 7'd119 || color_to_display !== 3'd5 ||
            drop_cnt !== 8'd3 || eng.gnt !== 4'b0) begin
            errors++;
            $display("FAIL drop_edge plot=%b x=%0d y=%0d c=%0d drop=%0d gnt=%b exp 1 159 119 5 3 0000",
                     plot, VGA_X, VGA_Y, color_to_display, drop_cnt, eng.gnt);
        end
        clear_inputs();
        $display("test_offscreen_drop done");
    endtask

    task automatic test_drop_saturate;
        do_reset();
        eng.req = 4'b0001;
        tick();
        set_pix(0, 8'd255, 7'd0, 3'd0, 1'b1, 1'b0);
        repeat (254) tick();
        checks++;
        if (drop_cnt !== 8'd254) begin
            errors++;
            $display("FAIL sat_254 drop=%0d exp 254", drop_cnt);
        end
        repeat (4) tick();
        checks++;
        if (drop_cnt !== 8'd255 || eng.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL sat_255 drop=%0d gnt=%b exp 255 0001", drop_cnt, eng.gnt);
        end
        set_pix(0, 8'd200, 7'd0, 3'd0, 1'b1, 1'b1);
        tick();
        checks++;
        if (drop_cnt !== 8'd255 || eng.gnt !== 4'b0) begin
            errors++;
            $display("FAIL sat_hold drop=%0d gnt=%b exp 255 0000", drop_cnt, eng.gnt);
        end
        clear_inputs();
        $display("test_drop_saturate done");
    endtask

    task automatic test_abort;
        do_reset();
        eng.req = 4'b1010;
        tick();
        checks++;
        if (eng.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL abort_grant gnt=%b exp 0010", eng.gnt);
        end
        set_pix(1, 8'd40, 7'd50, 3'd3, 1'b1, 1'b0);
        tick();
        checks++;
        if (plot !== 1'b1 || VGA_X !== 8'd40 || eng.gnt !== 4'b0010) begin
            errors++;
            $display("FAIL abort_pix plot=%b x=%0d gnt=%b exp 1 40 0010", plot, VGA_X, eng.gnt);
        end
        eng.valid = 4'b0000;
        eng.req   = 4'b1000;
        tick();
        checks++;
        if (eng.gnt !== 4'b0 || busy !== 1'b0 || plot !== 1'b0) begin
            errors++;
            $display("FAIL abort_release gnt=%b busy=%b plot=%b exp 0000 0 0", eng.gnt, busy, plot);
        end
        tick();
        checks++;
        if (eng.gnt !== 4'b1000) begin
            errors++;
            $display("FAIL abort_next gnt=%b exp 1000", eng.gnt);
        end
        set_pix(3, 8'd77, 7'd8, 3'd4, 1'b1, 1'b0);
        eng.req = 4'b0000;
        tick();
        checks++;
        if (eng.gnt !== 4'b0 || plot !== 1'b1 || VGA_X !== 8'd77) begin
            errors++;
            $display("FAIL abort_valid gnt=%b plot=%b x=%0d exp 0000 1 77", eng.gnt, plot, VGA_X);
        end
        clear_inputs();
        $display("test_abort done");
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        eng.req = 4'b0001;
        tick();
        set_pix(0, 8'd170, 7'd0, 3'd1, 1'b1, 1'b0);
        tick();
        checks++;
        if (drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL rst_pre_drop drop=%0d exp 1", drop_cnt);
        end
        set_pix(0, 8'd3, 7'd4, 3'd6, 1'b1, 1'b0);
        tick();
        checks++;
        if (plot !== 1'b1 || VGA_X !== 8'd3) begin
            errors++;
            $display("FAIL rst_pre_plot plot=%b x=%0d exp 1 3", plot, VGA_X);
        end
        resetn  = 1'b0;
        eng.req = 4'b1111;
        #1;
        checks++;
        if (eng.gnt !== 4'b0 || plot !== 1'b0 || drop_cnt !== 8'd0 || busy !== 1'b0 || VGA_X !== 8'd0) begin
            errors++;
            $display("FAIL rst_async gnt=%b plot=%b drop=%0d busy=%b x=%0d exp all zero",
                     eng.gnt, plot, drop_cnt, busy, VGA_X);
        end
        tick();
        resetn = 1'b1;
        tick();
        checks++;
        if (eng.gnt !== 4'b0001 || plot !== 1'b0) begin
            errors++;
            $display("FAIL rst_first_grant gnt=%b plot=%b exp 0001 0", eng.gnt, plot);
        end
        tick();
        checks++;
        if (plot !== 1'b1 || VGA_X !== 8'd3) begin
            errors++;
            $display("FAIL rst_resume plot=%b x=%0d exp 1 3", plot, VGA_X);
        end
        clear_inputs();
        $display("test_reset_mid_burst done");
    endtask

    task automatic test_idle_owner;
        do_reset();
        eng.req = 4'b0001;
        tick();
        checks++;
        if (eng.gnt !== 4'b0001) begin
            errors++;
            $display("FAIL idle_grant gnt=%b exp 0001", eng.gnt);
        end
`ifdef PLOT_ARB_WATCHDOG_EN
        repeat (15) tick();
        checks++;
        if (eng.gnt !== 4'b0001 || wdog_trip !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early gnt=%b trip=%b exp 0001 0", eng.gnt, wdog_trip);
        end
        tick();
        checks++;
        if (eng.gnt !== 4'b0 || wdog_trip !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wdog_fire gnt=%b trip=%b busy=%b exp 0000 1 0", eng.gnt, wdog_trip, busy);
        end
        tick();
        checks++;
        if (wdog_trip !== 1'b0) begin
            errors++;
            $display("FAIL wdog_pulse trip=%b exp 0", wdog_trip);
        end
`else
        repeat (110) tick();
        checks++;
        if (eng.gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_grant gnt=%b busy=%b exp 0001 1", eng.gnt, busy);
        end
`endif
        clear_inputs();
        $display("test_idle_owner done");
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        test_reset();
        test_basic_burst();
        test_round_robin();
        test_offscreen_drop();
        test_drop_saturate();
        test_abort();
        test_reset_mid_burst();
        test_idle_owner();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
